// File: rtl/mux_full_parallel_sel_if.sv
// -----------------------------------------------------------------------------
// mux_full_parallel_sel_if
//
// Purpose:
//   Bundles the select, data-input and data-output signals of one
//   mux_full_parallel_sel instance. Clock and reset are not part of the
//   bundle; they stay as plain scalar ports on the multiplexer.
//
// Parameters:
//   SIZE       data width of every input and output
//   SEL_WIDTH  number of select bits (2, 3 or 4)
//
// Signals:
//   Sel   index select, driven by the master
//   I     sixteen data inputs, driven by the master; entries at index
//         2**SEL_WIDTH and above are inactive
//   O     combinational selected data, driven by the slave
//   oQ    registered selected data, driven by the slave
//
// Modports:
//   master  the consumer that drives Sel/I and reads O/oQ
//   slave   the multiplexer side
// -----------------------------------------------------------------------------
interface mux_full_parallel_sel_if #(
  parameter int SIZE      = 8,
  parameter int SEL_WIDTH = 4
);

  logic [SEL_WIDTH-1:0] Sel;
  logic [SIZE-1:0]      I [16];
  logic [SIZE-1:0]      O;
  logic [SIZE-1:0]      oQ;

  modport master (
    output Sel,
    output I,
    input  O,
    input  oQ
  );

  modport slave (
    input  Sel,
    input  I,
    output O,
    output oQ
  );

endinterface : mux_full_parallel_sel_if

// File: rtl/mux_full_parallel_sel.sv
// -----------------------------------------------------------------------------
// mux_full_parallel_sel
//
// Purpose:
//   Generic full-parallel N-to-1 data multiplexer for the MMU read path.
//   One block covers the 4-, 8- and 16-input variants, chosen by SEL_WIDTH.
//   O is a zero-latency combinational selection. oQ is the same value
//   registered once, for pipelined consumers.
//
// Parameters:
//   SIZE       data width in bits (first positional parameter)
//   SEL_WIDTH  select width: 2 -> I0..I3, 3 -> I0..I7, 4 -> I0..I15
//
// Ports:
//   iClock   in   1          rising edge clocks oQ only
//   iReset   in   1          asynchronous active-low reset of oQ only
//   Sel      in   SEL_WIDTH  input index select
//   I0..I15  in   SIZE       data inputs; inputs above 2**SEL_WIDTH-1 ignored
//   O        out  SIZE       combinational selected data
//   oQ       out  SIZE       O delayed by one iClock cycle, zero in reset
// -----------------------------------------------------------------------------
module mux_full_parallel_sel #(
  parameter int SIZE      = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic [SEL_WIDTH-1:0] Sel,
  input  logic [SIZE-1:0]      I0,
  input  logic [SIZE-1:0]      I1,
  input  logic [SIZE-1:0]      I2,
  input  logic [SIZE-1:0]      I3,
  input  logic [SIZE-1:0]      I4,
  input  logic [SIZE-1:0]      I5,
  input  logic [SIZE-1:0]      I6,
  input  logic [SIZE-1:0]      I7,
  input  logic [SIZE-1:0]      I8,
  input  logic [SIZE-1:0]      I9,
  input  logic [SIZE-1:0]      I10,
  input  logic [SIZE-1:0]      I11,
  input  logic [SIZE-1:0]      I12,
  input  logic [SIZE-1:0]      I13,
  input  logic [SIZE-1:0]      I14,
  input  logic [SIZE-1:0]      I15,
  output logic [SIZE-1:0]      O,
  output logic [SIZE-1:0]      oQ
);

  // Selected data, produced by exactly one of the generate branches below.
  logic [SIZE-1:0] o_s;
  // One-cycle delayed copy of o_s.
  logic [SIZE-1:0] q_r;

  // Each select width gets its own case so the items match the width of Sel
  // exactly. Every Sel code has an item, so the default is only taken for
  // X/Z select values and no latch can form.
  generate
    if (SEL_WIDTH == 2) begin : g_sel2

      // Inputs I4..I15 are ports only; they are folded here so they are
      // visibly consumed without reaching the output.
      logic unused_inactive_s;
      assign unused_inactive_s = ^{I4, I5, I6, I7, I8, I9, I10, I11,
                                   I12, I13, I14, I15};

      // 4-input parallel selection.
      always_comb begin
        o_s = {SIZE{1'b0}};
        case (Sel)
          2'd0:    o_s = I0;
          2'd1:    o_s = I1;
          2'd2:    o_s = I2;
          2'd3:    o_s = I3;
          default: o_s = {SIZE{1'b0}};
        endcase
      end

    end else if (SEL_WIDTH == 3) begin : g_sel3

      // Inputs I8..I15 are ports only and never reach the output.
      logic unused_inactive_s;
      assign unused_inactive_s = ^{I8, I9, I10, I11, I12, I13, I14, I15};

      // 8-input parallel selection.
      always_comb begin
        o_s = {SIZE{1'b0}};
        case (Sel)
          3'd0:    o_s = I0;
          3'd1:    o_s = I1;
          3'd2:    o_s = I2;
          3'd3:    o_s = I3;
          3'd4:    o_s = I4;
          3'd5:    o_s = I5;
          3'd6:    o_s = I6;
          3'd7:    o_s = I7;
          default: o_s = {SIZE{1'b0}};
        endcase
      end

    end else begin : g_sel4

      // 16-input parallel selection (SEL_WIDTH == 4, the only other legal
      // value).
      always_comb begin
        o_s = {SIZE{1'b0}};
        case (Sel)
          4'd0:    o_s = I0;
          4'd1:    o_s = I1;
          4'd2:    o_s = I2;
          4'd3:    o_s = I3;
          4'd4:    o_s = I4;
          4'd5:    o_s = I5;
          4'd6:    o_s = I6;
          4'd7:    o_s = I7;
          4'd8:    o_s = I8;
          4'd9:    o_s = I9;
          4'd10:   o_s = I10;
          4'd11:   o_s = I11;
          4'd12:   o_s = I12;
          4'd13:   o_s = I13;
          4'd14:   o_s = I14;
          4'd15:   o_s = I15;
          default: o_s = {SIZE{1'b0}};
        endcase
      end

    end
  endgenerate

  // Pipelined copy of the selection; cleared asynchronously while iReset is low.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      q_r <= {SIZE{1'b0}};
    end else begin
      q_r <= o_s;
    end
  end

  // O bypasses the register entirely, so it stays valid during reset.
  assign O  = o_s;
  assign oQ = q_r;

endmodule : mux_full_parallel_sel

// File: tb/tb_mux_full_parallel_sel.sv
module tb_mux_full_parallel_sel;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_full_parallel_sel_if #(8, 4) if4 ();
  mux_full_parallel_sel_if #(8, 3) if3 ();
  mux_full_parallel_sel_if #(8, 2) if2 ();

  mux_full_parallel_sel #(8, 4) u_dut4 (
    .iClock(clk), .iReset(rst_n), .Sel(if4.Sel),
    .I0(if4.I[0]),   .I1(if4.I[1]),   .I2(if4.I[2]),   .I3(if4.I[3]),
    .I4(if4.I[4]),   .I5(if4.I[5]),   .I6(if4.I[6]),   .I7(if4.I[7]),
    .I8(if4.I[8]),   .I9(if4.I[9]),   .I10(if4.I[10]), .I11(if4.I[11]),
    .I12(if4.I[12]), .I13(if4.I[13]), .I14(if4.I[14]), .I15(if4.I[15]),
    .O(if4.O), .oQ(if4.oQ)
  );

  mux_full_parallel_sel #(8, 3) u_dut3 (
    .iClock(clk), .iReset(rst_n), .Sel(if3.Sel),
    .I0(if3.I[0]),   .I1(if3.I[1]),   .I2(if3.I[2]),   .I3(if3.I[3]),
    .I4(if3.I[4]),   .I5(if3.I[5]),   .I6(if3.I[6]),   .I7(if3.I[7]),
    .I8(if3.I[8]),   .I9(if3.I[9]),   .I10(if3.I[10]), .I11(if3.I[11]),
    .I12(if3.I[12]), .I13(if3.I[13]), .I14(if3.I[14]), .I15(if3.I[15]),
    .O(if3.O), .oQ(if3.oQ)
  );

  mux_full_parallel_sel #(8, 2) u_dut2 (
    .iClock(clk), .iReset(rst_n), .Sel(if2.Sel),
    .I0(if2.I[0]),   .I1(if2.I[1]),   .I2(if2.I[2]),   .I3(if2.I[3]),
    .I4(if2.I[4]),   .I5(if2.I[5]),   .I6(if2.I[6]),   .I7(if2.I[7]),
    .I8(if2.I[8]),   .I9(if2.I[9]),   .I10(if2.I[10]), .I11(if2.I[11]),
    .I12(if2.I[12]), .I13(if2.I[13]), .I14(if2.I[14]), .I15(if2.I[15]),
    .O(if2.O), .oQ(if2.oQ)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] d4 [16];
  logic [7:0] d3 [16];
  logic [7:0] d2 [16];
  int unsigned s4, s3, s2;

  // Reference model: index into the input table; codes beyond the active
  // input count produce zero.
  function automatic logic [7:0] model_mux(input logic [7:0] d [16],
                                           input int unsigned sel,
                                           input int sw);
    if (sel >= (32'd1 << sw)) return 8'h00;
    return d[sel];
  endfunction

  task automatic apply();
    if4.I = d4; if4.Sel = 4'(s4);
    if3.I = d3; if3.Sel = 3'(s3);
    if2.I = d2; if2.Sel = 2'(s2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d4[i] = 8'h10 + 8'(i);
      d3[i] = 8'($urandom);
      d2[i] = 8'($urandom);
    end
    s4 = 0; s3 = 1; s2 = 2;
    apply();
    #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL reset_oq4 got %h exp 00", if4.oQ); end
    checks++; if (if3.oQ !== 8'h00) begin errors++; $display("FAIL reset_oq3 got %h exp 00", if3.oQ); end
    checks++; if (if2.oQ !== 8'h00) begin errors++; $display("FAIL reset_oq2 got %h exp 00", if2.oQ); end
    checks++; if (if4.O !== 8'h10) begin errors++; $display("FAIL reset_o4_valid got %h exp 10", if4.O); end
    checks++; if (if3.O !== d3[1]) begin errors++; $display("FAIL reset_o3_valid got %h exp %h", if3.O, d3[1]); end
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL reset_hold_oq4 got %h exp 00", if4.oQ); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL release_no_capture got %h exp 00", if4.oQ); end
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h10) begin errors++; $display("FAIL first_capture got %h exp 10", if4.oQ); end
    checks++; if (if2.oQ !== d2[2]) begin errors++; $display("FAIL first_capture2 got %h exp %h", if2.oQ, d2[2]); end
  endtask

  task automatic test_sweep4();
    for (int i = 0; i < 16; i++) d4[i] = 8'h10 + 8'(i);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk); s4 = s; apply(); #1;
      checks++;
      if (if4.O !== 8'h10 + 8'(s)) begin errors++; $display("FAIL sweep4_o sel=%0d got %h exp %h", s, if4.O, 8'h10 + 8'(s)); end
      @(posedge clk); #1;
      checks++;
      if (if4.oQ !== 8'h10 + 8'(s)) begin errors++; $display("FAIL sweep4_oq sel=%0d got %h exp %h", s, if4.oQ, 8'h10 + 8'(s)); end
    end
  endtask

  task automatic test_sel3();
    logic [7:0] exp_v [3];
    int unsigned sel_v [3];
    for (int i = 0; i < 16; i++) d3[i] = (i >= 8) ? 8'hFF : 8'h00;
    d3[0] = 8'hAA; d3[1] = 8'h21; d3[2] = 8'h22; d3[3] = 8'h23; d3[4] = 8'h91;
    sel_v[0] = 4; sel_v[1] = 0; sel_v[2] = 7;
    exp_v[0] = 8'h91; exp_v[1] = 8'hAA; exp_v[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); s3 = sel_v[k]; apply(); #1;
      checks++;
      if (if3.O !== exp_v[k]) begin errors++; $display("FAIL sel3_directed sel=%0d got %h exp %h", sel_v[k], if3.O, exp_v[k]); end
    end
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); s3 = s; apply(); #1;
      checks++;
      if (if3.O !== model_mux(d3, s3, 3) || if3.O === 8'hFF) begin
        errors++; $display("FAIL sel3_inactive sel=%0d got %h exp %h", s, if3.O, model_mux(d3, s3, 3));
      end
    end
  endtask

  task automatic test_sel2();
    for (int i = 4; i < 16; i++) d2[i] = 8'($urandom);
    d2[0] = 8'h3C; d2[1] = 8'h3C; d2[2] = 8'hC3; d2[3] = 8'hC3;
    @(negedge clk); s2 = 1; apply(); #1;
    checks++; if (if2.O !== 8'h3C) begin errors++; $display("FAIL sel2_01 got %h exp 3C", if2.O); end
    @(negedge clk); s2 = 2; apply(); #1;
    checks++; if (if2.O !== 8'hC3) begin errors++; $display("FAIL sel2_10 got %h exp C3", if2.O); end
    for (int t = 0; t < 4; t++) begin
      d2[0] = ~d2[0]; apply(); #1;
      checks++; if (if2.O !== 8'hC3) begin errors++; $display("FAIL sel2_toggle_i0 got %h exp C3", if2.O); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); s4 = 5; d4[5] = 8'h55; apply();
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h55) begin errors++; $display("FAIL mid_pre got %h exp 55", if4.oQ); end
    #1; rst_n = 1'b0; #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL mid_async_clear got %h exp 00", if4.oQ); end
    checks++; if (if4.O !== 8'h55) begin errors++; $display("FAIL mid_o_valid got %h exp 55", if4.O); end
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL mid_hold got %h exp 00", if4.oQ); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (if4.oQ !== 8'h00) begin errors++; $display("FAIL mid_release got %h exp 00", if4.oQ); end
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h55) begin errors++; $display("FAIL mid_recapture got %h exp 55", if4.oQ); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); d4[2] = 8'h01; d4[3] = 8'h02; s4 = 2; apply();
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h01) begin errors++; $display("FAIL b2b_q1 got %h exp 01", if4.oQ); end
    #2; s4 = 3; apply(); #1;
    checks++; if (if4.O !== 8'h02) begin errors++; $display("FAIL b2b_o_now got %h exp 02", if4.O); end
    checks++; if (if4.oQ !== 8'h01) begin errors++; $display("FAIL b2b_q_hold got %h exp 01", if4.oQ); end
    @(posedge clk); #1;
    checks++; if (if4.oQ !== 8'h02) begin errors++; $display("FAIL b2b_q2 got %h exp 02", if4.oQ); end
  endtask

  task automatic test_random();
    logic [7:0] e4, e3, e2;
    int unsigned idx;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        d4[i] = 8'($urandom); d3[i] = 8'($urandom); d2[i] = 8'($urandom);
      end
      s4 = $urandom_range(15, 0); s3 = $urandom_range(7, 0); s2 = $urandom_range(3, 0);
      apply(); #1;
      e4 = model_mux(d4, s4, 4); e3 = model_mux(d3, s3, 3); e2 = model_mux(d2, s2, 2);
      checks++; if (if4.O !== e4) begin errors++; $display("FAIL rand_o4 sel=%0d got %h exp %h", s4, if4.O, e4); end
      checks++; if (if3.O !== e3) begin errors++; $display("FAIL rand_o3 sel=%0d got %h exp %h", s3, if3.O, e3); end
      checks++; if (if2.O !== e2) begin errors++; $display("FAIL rand_o2 sel=%0d got %h exp %h", s2, if2.O, e2); end
      // Disturb one non-selected input per instance; outputs must not move.
      idx = $urandom_range(15, 0); if (idx == s4) idx = (idx + 1) % 16; d4[idx] = ~d4[idx];
      idx = $urandom_range(15, 0); if (idx == s3) idx = (idx + 1) % 16; d3[idx] = ~d3[idx];
      idx = $urandom_range(15, 0); if (idx == s2) idx = (idx + 1) % 16; d2[idx] = ~d2[idx];
      apply(); #1;
      checks++; if (if4.O !== e4) begin errors++; $display("FAIL rand_nonsel4 got %h exp %h", if4.O, e4); end
      checks++; if (if3.O !== e3) begin errors++; $display("FAIL rand_nonsel3 got %h exp %h", if3.O, e3); end
      checks++; if (if2.O !== e2) begin errors++; $display("FAIL rand_nonsel2 got %h exp %h", if2.O, e2); end
      @(posedge clk); #1;
      checks++; if (if4.oQ !== e4) begin errors++; $display("FAIL rand_oq4 got %h exp %h", if4.oQ, e4); end
      checks++; if (if3.oQ !== e3) begin errors++; $display("FAIL rand_oq3 got %h exp %h", if3.oQ, e3); end
      checks++; if (if2.oQ !== e2) begin errors++; $display("FAIL rand_oq2 got %h exp %h", if2.oQ, e2); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep4();
    test_sel3();
    test_sel2();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_full_parallel_sel
